// File: rtl/max_pool_engine.sv
// max_pool_engine: 2x2, stride-2 signed max-pooling from conv RAM into pool RAM.
// Build macro POOL_RELU_EN: when defined, negative window maxima are written as 0.
module max_pool_engine #(
  parameter int DATA_W    = 16,
  parameter int ADDR_BITS = 16,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    conv_rdata,
  output logic [ADDR_BITS-1:0] RAM_CONV_A,
  output logic                 RAM_CONV_OE,
  output logic [ADDR_BITS-1:0] RAM_POOL_A,
  output logic                 RAM_POOL_WE,
  output logic [DATA_W-1:0]    pool_wdata,
  output logic                 busy,
  output logic                 done
);

  // state  | meaning
  // IDLE   | waiting for start, all enables low
  // R0..R3 | read TL, TR, BL, BR of the current window
  // LAST   | BR word arrives, no read issued
  // WR     | write window max to pool RAM
  // FIN    | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_R0, S_R1, S_R2, S_R3, S_LAST, S_WR, S_FIN
  } state_t;

  localparam logic [ADDR_BITS-1:0] IMG_W_A  = ADDR_BITS'(IMG_W);
  localparam logic [ADDR_BITS-1:0] HALF_W_A = ADDR_BITS'(IMG_W / 2);
  localparam logic [ADDR_BITS-1:0] LAST_I   = ADDR_BITS'(IMG_H / 2 - 1);
  localparam logic [ADDR_BITS-1:0] LAST_J   = ADDR_BITS'(IMG_W / 2 - 1);

  state_t state, state_nxt;
  logic [ADDR_BITS-1:0] row_i, row_i_nxt, col_j, col_j_nxt;
  logic signed [DATA_W-1:0] max_q, max_nxt, rdata_s, word_max;

  logic [ADDR_BITS-1:0] tl_addr, pool_addr;
  logic [ADDR_BITS-1:0] conv_a_nxt, pool_a_nxt;
  logic                 oe_nxt, we_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0]    wdata_nxt;

  assign rdata_s  = $signed(conv_rdata);
  assign word_max = (rdata_s > max_q) ? rdata_s : max_q;

  // Outputs are registered, so addresses are derived from the next window indices.
  assign tl_addr   = ((row_i_nxt << 1) * IMG_W_A) + (col_j_nxt << 1);
  assign pool_addr = (row_i_nxt * HALF_W_A) + col_j_nxt;

  always_comb begin
    state_nxt = state;
    row_i_nxt = row_i;
    col_j_nxt = col_j;
    max_nxt   = max_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_R0;
          row_i_nxt = '0;
          col_j_nxt = '0;
        end
      end
      S_R0: state_nxt = S_R1;
      S_R1: begin
        state_nxt = S_R2;
        max_nxt   = rdata_s;
      end
      S_R2: begin
        state_nxt = S_R3;
        max_nxt   = word_max;
      end
      S_R3: begin
        state_nxt = S_LAST;
        max_nxt   = word_max;
      end
      S_LAST: begin
        state_nxt = S_WR;
        max_nxt   = word_max;
      end
      S_WR: begin
        if (row_i == LAST_I && col_j == LAST_J) begin
          state_nxt = S_FIN;
        end else begin
          state_nxt = S_R0;
          if (col_j == LAST_J) begin
            col_j_nxt = '0;
            row_i_nxt = row_i + 1'b1;
          end else begin
            col_j_nxt = col_j + 1'b1;
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    conv_a_nxt = '0;
    oe_nxt     = 1'b0;
    pool_a_nxt = '0;
    we_nxt     = 1'b0;
    wdata_nxt  = '0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state_nxt)
      S_R0: begin
        oe_nxt = 1'b1; busy_nxt = 1'b1; conv_a_nxt = tl_addr;
      end
      S_R1: begin
        oe_nxt = 1'b1; busy_nxt = 1'b1; conv_a_nxt = tl_addr + 1'b1;
      end
      S_R2: begin
        oe_nxt = 1'b1; busy_nxt = 1'b1; conv_a_nxt = tl_addr + IMG_W_A;
      end
      S_R3: begin
        oe_nxt = 1'b1; busy_nxt = 1'b1; conv_a_nxt = tl_addr + IMG_W_A + 1'b1;
      end
      S_LAST: busy_nxt = 1'b1;
      S_WR: begin
        we_nxt     = 1'b1;
        busy_nxt   = 1'b1;
        pool_a_nxt = pool_addr;
`ifdef POOL_RELU_EN
        wdata_nxt  = max_nxt[DATA_W-1] ? '0 : max_nxt;
`else
        wdata_nxt  = max_nxt;
`endif
      end
      S_FIN:   done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      row_i       <= '0;
      col_j       <= '0;
      max_q       <= '0;
      RAM_CONV_A  <= '0;
      RAM_CONV_OE <= 1'b0;
      RAM_POOL_A  <= '0;
      RAM_POOL_WE <= 1'b0;
      pool_wdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      row_i       <= row_i_nxt;
      col_j       <= col_j_nxt;
      max_q       <= max_nxt;
      RAM_CONV_A  <= conv_a_nxt;
      RAM_CONV_OE <= oe_nxt;
      RAM_POOL_A  <= pool_a_nxt;
      RAM_POOL_WE <= we_nxt;
      pool_wdata  <= wdata_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_max_pool_engine.sv
// Bench for max_pool_engine: a 4x4 instance for directed/table cases and a 256x256 instance for the full random pass.
module tb_max_pool_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small 4x4 instance
  logic        s_rst, s_start, s_oe, s_we, s_busy, s_done;
  logic [15:0] s_rdata = '0;
  logic [15:0] s_conv_a, s_pool_a, s_wdata;
  // default 256x256 instance
  logic        b_rst, b_start, b_oe, b_we, b_busy, b_done;
  logic [15:0] b_rdata = '0;
  logic [15:0] b_conv_a, b_pool_a, b_wdata;

  max_pool_engine #(.DATA_W(16), .ADDR_BITS(16), .IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .conv_rdata(s_rdata),
    .RAM_CONV_A(s_conv_a), .RAM_CONV_OE(s_oe), .RAM_POOL_A(s_pool_a),
    .RAM_POOL_WE(s_we), .pool_wdata(s_wdata), .busy(s_busy), .done(s_done));

  max_pool_engine u_big (
    .clk(clk), .rst(b_rst), .start(b_start), .conv_rdata(b_rdata),
    .RAM_CONV_A(b_conv_a), .RAM_CONV_OE(b_oe), .RAM_POOL_A(b_pool_a),
    .RAM_POOL_WE(b_we), .pool_wdata(b_wdata), .busy(b_busy), .done(b_done));

  logic [15:0] s_mem [16];
  logic [15:0] b_mem [65536];

  always @(posedge clk) begin
    if (s_oe) s_rdata <= s_mem[s_conv_a[3:0]];
    if (b_oe) b_rdata <= b_mem[b_conv_a];
  end

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t s_wr[$];
  wr_t b_wr[$];
  int  s_done_cnt = 0;
  int  b_done_cnt = 0;

  always @(negedge clk) begin
    if (s_we) s_wr.push_back({s_pool_a, s_wdata});
    if (b_we) b_wr.push_back({b_pool_a, b_wdata});
    if (s_done) s_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed max of the four window words, optionally clamped at zero.
  function automatic logic [15:0] ref_max(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
    int m;
    m = $signed(a);
    if ($signed(b) > m) m = $signed(b);
    if ($signed(c) > m) m = $signed(c);
    if ($signed(d) > m) m = $signed(d);
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m[15:0];
  endfunction

  function automatic logic [15:0] relu16(input logic [15:0] x);
`ifdef POOL_RELU_EN
    if (x[15]) return 16'h0000;
`endif
    return x;
  endfunction

  function automatic logic [15:0] small_ref(input int p);
    int base;
    base = (2 * (p / 2)) * 4 + 2 * (p % 2);
    return ref_max(s_mem[base], s_mem[base+1], s_mem[base+4], s_mem[base+5]);
  endfunction

  // Pulses (or holds) start, runs up to 40 cycles; k counts cycles after the start-sampling edge.
  task automatic run_small(input int extra_k, input int hold, output int done_k, output logic busy1);
    s_wr.delete();
    s_done_cnt = 0;
    done_k = -1;
    busy1 = 1'b0;
    @(negedge clk) s_start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = s_busy;
      if (k == 1 && hold == 0) s_start = 1'b0;
      if (k == extra_k) s_start = 1'b1;
      if (k == extra_k + 1 && hold == 0) s_start = 1'b0;
      if (s_done && done_k < 0) done_k = k;
      if (hold != 0 && done_k >= 0) break;
    end
  endtask

  task automatic check_small_pass(input string name, input int done_k, input logic busy1);
    check({name, "_wcount"}, s_wr.size(), 4);
    for (int p = 0; p < 4 && p < s_wr.size(); p++) begin
      check({name, "_addr"}, s_wr[p].a, p);
      check({name, "_data"}, s_wr[p].d, small_ref(p));
    end
    check({name, "_done_lat"}, done_k, 25);
    check({name, "_done_cnt"}, s_done_cnt, 1);
    check({name, "_busy_r0"}, busy1, 1'b1);
  endtask

  typedef struct packed { logic [3:0][15:0] v; logic [15:0] exp; } vec_t;
  vec_t tbl [7];

  initial begin
    int   dk;
    logic b1;
    int   bad_a, bad_d, big_k;
    logic [15:0] exp1 [4];

    tbl[0] = '{v: {16'hFFF7, 16'hFFFF, 16'hFFF9, 16'hFFFD}, exp: relu16(16'hFFFF)};
    tbl[1] = '{v: {16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF}, exp: 16'h7FFF};
    tbl[2] = '{v: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp: relu16(16'h8000)};
    tbl[3] = '{v: {16'h0004, 16'h0003, 16'h0002, 16'h0001}, exp: 16'h0004};
    tbl[4] = '{v: {16'h0063, 16'h0032, 16'hFF38, 16'h0064}, exp: 16'h0064};
    tbl[5] = '{v: {16'hFFFC, 16'hFFFB, 16'hFFFB, 16'hFFFB}, exp: relu16(16'hFFFC)};
    tbl[6] = '{v: {16'h8002, 16'hFFFF, 16'h8001, 16'h8000}, exp: relu16(16'hFFFF)};
    exp1[0] = 16'd5; exp1[1] = 16'd7; exp1[2] = 16'd13; exp1[3] = 16'd15;

    s_rst = 1'b1; b_rst = 1'b1; s_start = 1'b0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_small", {s_conv_a, s_pool_a, s_wdata, s_oe, s_we, s_busy, s_done}, 64'd0);
    check("reset_big",   {b_conv_a, b_pool_a, b_wdata, b_oe, b_we, b_busy, b_done}, 64'd0);
    s_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // ramp image 0..15
    for (int k = 0; k < 16; k++) s_mem[k] = 16'(k);
    run_small(-5, 0, dk, b1);
    check_small_pass("ramp", dk, b1);
    for (int p = 0; p < 4 && p < s_wr.size(); p++) check("ramp_const", s_wr[p].d, exp1[p]);

    // window-0 corner values (placed as TL,TR,BL,BR = v[0..3])
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 16; k++) s_mem[k] = 16'($urandom);
      s_mem[0] = tbl[t].v[0]; s_mem[1] = tbl[t].v[1];
      s_mem[4] = tbl[t].v[2]; s_mem[5] = tbl[t].v[3];
      run_small(-5, 0, dk, b1);
      check("tbl_count", s_wr.size(), 4);
      if (s_wr.size() > 0) check("tbl_win0", s_wr[0].d, tbl[t].exp);
    end

    // reset in R2 of window 1
    for (int k = 0; k < 16; k++) s_mem[k] = 16'($urandom);
    s_wr.delete();
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_r2_addr", {s_oe, s_conv_a}, {1'b1, 16'd6});
    s_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {s_conv_a, s_pool_a, s_wdata, s_oe, s_we, s_busy, s_done}, 64'd0);
    s_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_writes", s_wr.size(), 1);
    check("mid_rst_idle", {s_busy, s_oe, s_we}, 3'b000);
    run_small(-5, 0, dk, b1);
    check_small_pass("after_rst", dk, b1);

    // start pulses while busy, including just before FIN
    for (int k = 0; k < 16; k++) s_mem[k] = 16'($urandom);
    run_small(10, 0, dk, b1);
    check_small_pass("restart10", dk, b1);
    run_small(24, 0, dk, b1);
    check_small_pass("restart24", dk, b1);

    // start held through FIN: IDLE next cycle, then a new R0
    run_small(-5, 1, dk, b1);
    check("hold_done_lat", dk, 25);
    @(negedge clk);
    check("hold_idle", {s_busy, s_oe, s_done}, 3'b000);
    @(negedge clk);
    check("hold_rerun", {s_busy, s_oe, s_conv_a}, {2'b11, 16'd0});
    s_start = 1'b0; s_rst = 1'b1;
    @(negedge clk) s_rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) s_mem[k] = 16'($urandom);
      run_small(-5, 0, dk, b1);
      check_small_pass("rand_small", dk, b1);
    end

    // full 256x256 random pass
    for (int k = 0; k < 65536; k++) b_mem[k] = 16'($urandom);
    b_mem[0] = 16'h7FFF; b_mem[1] = 16'h8000; b_mem[256] = 16'h0001; b_mem[257] = 16'h7FFF;
    b_wr.delete();
    b_done_cnt = 0;
    big_k = -1;
    @(negedge clk) b_start = 1'b1;
    for (int k = 1; k <= 99000; k++) begin
      @(negedge clk);
      if (k == 1) b_start = 1'b0;
      if (b_done) begin
        big_k = k;
        break;
      end
    end
    check("big_done_lat", big_k, 6 * 16384 + 1);
    repeat (3) @(negedge clk);
    check("big_done_cnt", b_done_cnt, 1);
    check("big_wcount", b_wr.size(), 16384);
    bad_a = 0; bad_d = 0;
    for (int p = 0; p < b_wr.size(); p++) begin
      int base;
      logic [15:0] e;
      base = (2 * (p / 128)) * 256 + 2 * (p % 128);
      e = ref_max(b_mem[base], b_mem[base+1], b_mem[base+256], b_mem[base+257]);
      if (b_wr[p].a !== 16'(p)) bad_a++;
      if (b_wr[p].d !== e) bad_d++;
    end
    check("big_addr_errs", bad_a, 0);
    check("big_data_errs", bad_d, 0);
    if (b_wr.size() > 0) check("big_win0", b_wr[0].d, 16'h7FFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
